nios_system_nios2_gen2_0_cpu_oci_dct_packer: RTL and testbench
==============================================================

NIOS_SYSTEM_NIOS2_GEN2_0_CPU_OCI_DCT_PACKER -- requirements
Module: nios_system_nios2_gen2_0_cpu_oci_dct_packer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: ports clk and reset_n.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- sym_valid  in  1  trace symbol present this cycle
- sym_data  in  2  trace symbol
- flush  in  1  single-cycle request to emit the partial frame
- end_req  in  1  single-cycle request to end the trace session
- frame_ready  in  1  downstream accepts the frame
- frame_valid  out  1  output frame held
- dct_buffer  out  30  packed frame, 15 x 2-bit slots
- dct_count  out  4  valid symbols in dct_buffer, 1..15
- overflow  out  1  sticky: a symbol was dropped
- test_ending  out  1  session draining or ended
- test_has_ended  out  1  session ended, all frames delivered

Function
REQ-003 SHALL keep an internal accumulator acc[29:0] and acc_cnt (0..15); no parameters.
REQ-004 SHALL accept a symbol when sym_valid=1, state=RUN, and (acc_cnt<15 or a transfer occurs this cycle).
REQ-005 On accept without transfer, acc SHALL become {acc[27:0], sym_data} and acc_cnt SHALL increment.
REQ-006 A transfer SHALL occur when (acc_cnt==15 or flush_pend) and acc_cnt!=0 and the output slot is free (frame_valid==0 or frame_ready==1).
REQ-007 flush_pend SHALL be flush OR a registered pending flag; the flag SHALL set on flush with no transfer that cycle and clear on transfer.
REQ-008 flush with acc_cnt==0 SHALL be a no-op; it SHALL neither emit a frame nor leave the flag set.
REQ-009 On transfer: dct_buffer<=acc, dct_count<=acc_cnt, frame_valid<=1; acc/acc_cnt SHALL restart from a symbol accepted in the same cycle (acc={28'b0,sym_data}, acc_cnt=1), else 0/0.
REQ-010 Slot order: the oldest symbol SHALL occupy bits [2*dct_count-1 : 2*dct_count-2] and the newest bits [1:0]; unused upper bits SHALL be 0.
REQ-011 dct_buffer/dct_count SHALL hold stable while frame_valid=1 and frame_ready=0.
REQ-012 frame_valid SHALL clear on a cycle with frame_ready=1 and no new transfer; back-to-back transfer SHALL keep it 1.
REQ-013 Transfer-to-frame_valid latency SHALL be 1 cycle (registered outputs, no combinational input-to-output path).
REQ-014 sym_valid=1 in RUN with acc_cnt==15 and no transfer SHALL drop the symbol and set overflow; overflow SHALL clear only on reset.
REQ-015 FSM states SHALL be RUN, DRAIN, ENDED.
REQ-016 RUN->DRAIN on end_req; entry SHALL set the pending flush flag.
REQ-017 DRAIN->ENDED when acc_cnt==0, frame_valid==0 and no transfer this cycle.
REQ-018 ENDED SHALL be terminal until reset.
REQ-019 In DRAIN/ENDED, symbols SHALL be ignored without setting overflow; end_req and flush outside RUN SHALL be ignored beyond REQ-016.
REQ-020 test_ending SHALL be 1 in DRAIN and ENDED; test_has_ended SHALL be 1 only in ENDED.

Reset
REQ-021 reset_n=0 at a clock edge SHALL force frame_valid=0, dct_buffer=0, dct_count=0, overflow=0, test_ending=0, test_has_ended=0, acc=0, acc_cnt=0, pending flag=0, state=RUN.
REQ-022 Reset mid-frame or mid-drain SHALL discard all held data with no emitted frame.

Verification
REQ-023 Full frame: frame_ready=1, 15 consecutive symbols 2'b01 -> one cycle later frame_valid=1, dct_count=15, dct_buffer=30'h15555555.
REQ-024 Partial flush: symbols 3,2,1 then flush -> dct_count=3, dct_buffer=30'h39; flush at acc_cnt=0 -> no frame.
REQ-025 Backpressure/overflow: frame_ready=0, 31 symbols -> first frame held stable, second accumulator full, 31st dropped, overflow=1; frame_ready=1 -> second frame (count 15) next cycle.
REQ-026 Simultaneous: at acc_cnt=15 with slot free plus sym_valid=1 -> transfer, acc_cnt=1 holding the new symbol, overflow stays 0.
REQ-027 End: 4 symbols, end_req, frame_ready held 0 for 5 cycles -> test_ending=1, frame (count 4) held; after acceptance test_has_ended=1 next cycle; later symbols ignored, overflow=0.
REQ-028 Reset in DRAIN with frame held -> all outputs 0 next cycle, state RUN.

Source files
------------

// File: rtl/nios_system_nios2_gen2_0_cpu_oci_dct_packer.sv
// nios_system_nios2_gen2_0_cpu_oci_dct_packer: packs 2-bit trace symbols into 15-slot frames
// with flush, backpressure, overflow detection and an end-of-session drain.
module nios_system_nios2_gen2_0_cpu_oci_dct_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sym_valid,
    input  logic [1:0]  sym_data,
    input  logic        flush,
    input  logic        end_req,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        overflow,
    output logic        test_ending,
    output logic        test_has_ended
);
    typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_e;
    state_e      state_q, state_d;
    logic [29:0] acc_q, acc_d, buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d, dcnt_q, dcnt_d;
    logic        pend_q, pend_d, fv_q, fv_d, ovf_q, ovf_d;
    logic        run, flush_run, full, xfer, accept, drop;
    always_comb begin
        run       = state_q == RUN;
        flush_run = flush & run;
        full      = cnt_q == 4'd15;
        xfer      = (full | flush_run | pend_q) & (cnt_q != 4'd0) & (!fv_q | frame_ready);
        accept    = sym_valid & run & (!full | xfer);
        drop      = sym_valid & run & full & !xfer;
        // a transfer empties the accumulator, so a same-cycle symbol starts the next frame
        acc_d     = xfer ? (accept ? {28'b0, sym_data} : 30'b0)
                         : (accept ? {acc_q[27:0], sym_data} : acc_q);
        cnt_d     = xfer ? {3'b0, accept} : cnt_q + {3'b0, accept};
        pend_d    = (run & end_req) | (!xfer & (pend_q | (flush_run & (cnt_q != 4'd0))));
        fv_d      = xfer | (fv_q & !frame_ready);
        buf_d     = xfer ? acc_q : buf_q;
        dcnt_d    = xfer ? cnt_q : dcnt_q;
        ovf_d     = ovf_q | drop;
        state_d   = (run & end_req) ? DRAIN
                  : (state_q == DRAIN && cnt_q == 4'd0 && !fv_q) ? ENDED : state_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            dcnt_q  <= '0;
            pend_q  <= 1'b0;
            fv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dcnt_q  <= dcnt_d;
            pend_q  <= pend_d;
            fv_q    <= fv_d;
            ovf_q   <= ovf_d;
        end
    end
    assign frame_valid    = fv_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = dcnt_q;
    assign overflow       = ovf_q;
    assign test_ending    = state_q != RUN;
    assign test_has_ended = state_q == ENDED;
endmodule

// File: tb/tb_nios_system_nios2_gen2_0_cpu_oci_dct_packer.sv
// tb_nios_system_nios2_gen2_0_cpu_oci_dct_packer: scenario tasks plus randomized run against a
// symbol-queue reference model of the packer.
module tb_nios_system_nios2_gen2_0_cpu_oci_dct_packer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym_data = 2'b0;
    logic        flush = 1'b0;
    logic        end_req = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_ending;
    logic        test_has_ended;

    int n_chk = 0;
    int n_err = 0;

    nios_system_nios2_gen2_0_cpu_oci_dct_packer dut (
        .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym_data(sym_data),
        .flush(flush), .end_req(end_req), .frame_ready(frame_ready),
        .frame_valid(frame_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .overflow(overflow), .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    wire [37:0] got = {frame_valid, dct_buffer, dct_count, overflow, test_ending, test_has_ended};

    // reference model: accumulator as a queue of symbols, oldest first
    bit [1:0]    q[$];
    bit          m_fv, m_ovf, m_pend;
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;
    int          m_st;

    function automatic logic [29:0] pack();
        logic [29:0] v = '0;
        foreach (q[i]) v = (v << 2) | 30'(q[i]);
        return v;
    endfunction

    function automatic logic [37:0] exp_vec();
        return {m_fv, m_buf, m_cnt, m_ovf, m_st != 0, m_st == 2};
    endfunction

    task automatic cyc(input bit rn, input bit sv, input bit [1:0] sd,
                       input bit fl, input bit er, input bit rdy);
        bit run, xfer, acc;
        int n;
        reset_n = rn; sym_valid = sv; sym_data = sd; flush = fl; end_req = er; frame_ready = rdy;
        if (!rn) begin
            q.delete(); m_fv = 0; m_buf = '0; m_cnt = '0; m_ovf = 0; m_pend = 0; m_st = 0;
        end else begin
            run  = m_st == 0;
            n    = q.size();
            xfer = (n == 15 || (fl && run) || m_pend) && n != 0 && (!m_fv || rdy);
            acc  = sv && run && (n < 15 || xfer);
            if (sv && run && !acc) m_ovf = 1;
            if (m_st == 1 && n == 0 && !m_fv) m_st = 2;
            else if (run && er) m_st = 1;
            if (run && er) m_pend = 1;
            else if (xfer) m_pend = 0;
            else if (fl && run && n != 0) m_pend = 1;
            if (xfer) begin
                m_buf = pack(); m_cnt = 4'(n); q.delete();
            end
            m_fv = xfer || (m_fv && !rdy);
            if (acc) q.push_back(sd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 1, 2'($urandom), 1, 1, 1);
        cyc(0, 1, 2'($urandom), 0, 0, 0);
        n_chk++;
        if (got !== 38'b0) begin
            n_err++; $display("FAIL reset: got %h required 0", got);
        end
    endtask

    task automatic test_full_frame();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            cyc(1, 1, 2'b01, 0, 0, 1);
            n_chk++;
            if (got !== exp_vec()) begin
                n_err++; $display("FAIL full_fill[%0d]: got %h required %h", i, got, exp_vec());
            end
        end
        cyc(1, 0, 0, 0, 0, 1);
        n_chk++;
        if ({frame_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, 30'h15555555}) begin
            n_err++;
            $display("FAIL full_frame: got fv=%b cnt=%0d buf=%h required 1/15/15555555",
                     frame_valid, dct_count, dct_buffer);
        end
    endtask

    task automatic test_flush();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 1, 2'd3, 0, 0, 1);
        cyc(1, 1, 2'd2, 0, 0, 1);
        cyc(1, 1, 2'd1, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 1);
        n_chk++;
        if ({frame_valid, dct_count, dct_buffer} !== {1'b1, 4'd3, 30'h39}) begin
            n_err++;
            $display("FAIL partial_flush: got fv=%b cnt=%0d buf=%h required 1/3/39",
                     frame_valid, dct_count, dct_buffer);
        end
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        n_chk++;
        if (frame_valid !== 1'b0) begin
            n_err++; $display("FAIL empty_flush: got fv=%b required 0", frame_valid);
        end
    endtask

    task automatic test_backpressure();
        bit [1:0]    s[31];
        logic [29:0] f1, f2;
        f1 = '0; f2 = '0;
        foreach (s[i]) s[i] = 2'($urandom);
        for (int i = 0; i < 15; i++) f1 = (f1 << 2) | 30'(s[i]);
        for (int i = 15; i < 30; i++) f2 = (f2 << 2) | 30'(s[i]);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) begin
            cyc(1, 1, s[i], 0, 0, 0);
            if (i >= 15) begin
                n_chk++;
                if ({frame_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, f1}) begin
                    n_err++;
                    $display("FAIL bp_hold[%0d]: got fv=%b cnt=%0d buf=%h required 1/15/%h",
                             i, frame_valid, dct_count, dct_buffer, f1);
                end
            end
            n_chk++;
            if (overflow !== (i == 30)) begin
                n_err++; $display("FAIL bp_ovf[%0d]: got %b required %b", i, overflow, i == 30);
            end
        end
        cyc(1, 0, 0, 0, 0, 1);
        n_chk++;
        if ({frame_valid, dct_count, dct_buffer, overflow} !== {1'b1, 4'd15, f2, 1'b1}) begin
            n_err++;
            $display("FAIL bp_second: got fv=%b cnt=%0d buf=%h ovf=%b required 1/15/%h/1",
                     frame_valid, dct_count, dct_buffer, overflow, f2);
        end
    endtask

    task automatic test_simultaneous();
        bit [1:0] s16;
        s16 = 2'($urandom);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'($urandom), 0, 0, 1);
        cyc(1, 1, s16, 0, 0, 1);
        n_chk++;
        if ({frame_valid, dct_count, overflow} !== {1'b1, 4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL simul_xfer: got fv=%b cnt=%0d ovf=%b required 1/15/0",
                     frame_valid, dct_count, overflow);
        end
        cyc(1, 0, 0, 1, 0, 1);
        n_chk++;
        if ({frame_valid, dct_count, dct_buffer} !== {1'b1, 4'd1, 28'b0, s16}) begin
            n_err++;
            $display("FAIL simul_carry: got fv=%b cnt=%0d buf=%h required 1/1/%h",
                     frame_valid, dct_count, dct_buffer, s16);
        end
    endtask

    task automatic test_end();
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 2'($urandom), 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 2'($urandom), 1, 0, 0);
        n_chk++;
        if ({test_ending, test_has_ended, frame_valid, dct_count, overflow} !== {3'b101, 4'd4, 1'b0}) begin
            n_err++;
            $display("FAIL end_drain: got te=%b th=%b fv=%b cnt=%0d ovf=%b required 1/0/1/4/0",
                     test_ending, test_has_ended, frame_valid, dct_count, overflow);
        end
        cyc(1, 0, 0, 0, 0, 1);
        n_chk++;
        if ({frame_valid, test_has_ended} !== 2'b00) begin
            n_err++; $display("FAIL end_accept: got fv=%b th=%b required 0/0", frame_valid, test_has_ended);
        end
        cyc(1, 0, 0, 0, 0, 1);
        n_chk++;
        if ({test_ending, test_has_ended} !== 2'b11) begin
            n_err++; $display("FAIL end_done: got te=%b th=%b required 1/1", test_ending, test_has_ended);
        end
        for (int i = 0; i < 4; i++) cyc(1, 1, 2'($urandom), 1, 1, 1);
        n_chk++;
        if ({frame_valid, overflow, test_has_ended} !== 3'b001) begin
            n_err++;
            $display("FAIL end_ignore: got fv=%b ovf=%b th=%b required 0/0/1",
                     frame_valid, overflow, test_has_ended);
        end
    endtask

    task automatic test_reset_drain();
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 2'($urandom), 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 2'($urandom), 0, 0, 0);
        n_chk++;
        if (got !== 38'b0) begin
            n_err++; $display("FAIL reset_drain: got %h required 0", got);
        end
        cyc(1, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        n_chk++;
        if (got !== 38'b0) begin
            n_err++; $display("FAIL reset_discard: got %h required 0", got);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, 2'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 2, $urandom_range(0, 9) < 6);
            n_chk++;
            if (got !== exp_vec()) begin
                n_err++; $display("FAIL random[%0d]: got %h required %h", i, got, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_backpressure();
        test_simultaneous();
        test_end();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
